// File: rtl/gtz_pkg.sv
// Shared types and helpers for the single-bin Goertzel tone detector.
// Holds the FSM state enum, the MAC op select, the default coefficient Q-format and a clamp helper.
package gtz_pkg;

   typedef enum logic [2:0] {
      ST_ACCUM,
      ST_MUL1,
      ST_MUL2,
      ST_MUL3,
      ST_MUL4,
      ST_DONE
   } gtz_state_e;

   typedef enum logic [1:0] {
      MAC_LOAD,
      MAC_ADD,
      MAC_SUB,
      MAC_PASS_SHIFT
   } mac_op_e;

   localparam int CW_DEFAULT = 16;
   localparam int CFRAC      = CW_DEFAULT - 2;

   // Clamp a signed value into the range of a two's-complement word of the given width.
   function automatic longint sat_signed(input longint value, input int width);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (width - 1)) - 1;
      lo = -hi - 1;
      if (value > hi) begin
         return hi;
      end else if (value < lo) begin
         return lo;
      end
      return value;
   endfunction

endpackage

// File: rtl/gtz_mac.sv
// Shared signed SWxSW multiplier with a wide power accumulator and a scaled-product register.
// The raw shifted product is also exported combinationally for the resonator update.
module gtz_mac
   import gtz_pkg::*;
#(
   parameter int SW   = 32,
   parameter int FRAC = CFRAC
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en_i,
   input  mac_op_e                op_i,
   input  logic signed [SW-1:0]   a_i,
   input  logic signed [SW-1:0]   b_i,
   output logic signed [SW+1:0]   prod_sh_o,
   output logic signed [SW-1:0]   t_o,
   output logic signed [2*SW+1:0] acc_d_o
);

   localparam int AW = 2 * SW + 2;

   logic signed [2*SW-1:0] prod;
   logic signed [AW-1:0]   prod_ext;
   logic signed [AW-1:0]   acc_q, acc_d;
   logic signed [SW-1:0]   t_q, t_d;

   assign prod      = a_i * b_i;
   assign prod_ext  = {{2{prod[2*SW-1]}}, prod};
   assign prod_sh_o = (SW+2)'(prod >>> FRAC);

   always_comb begin
      acc_d = acc_q;
      t_d   = t_q;
      if (en_i) begin
         case (op_i)
            MAC_LOAD:       acc_d = prod_ext;
            MAC_ADD:        acc_d = acc_q + prod_ext;
            MAC_SUB:        acc_d = acc_q - prod_ext;
            MAC_PASS_SHIFT: t_d   = SW'(prod >>> FRAC);
            default:        acc_d = acc_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         t_q   <= '0;
      end else begin
         acc_q <= acc_d;
         t_q   <= t_d;
      end
   end

   assign t_o     = t_q;
   assign acc_d_o = acc_d;

endmodule

// File: rtl/goertzel_tone_detector.sv
// Single-bin Goertzel analyser: runs the resonator over BLK_LEN samples, then emits bin power.
// Optional macro GTZ_SAT_EN: saturate the resonator state and report it on ovf (else wrap, ovf=0).
module goertzel_tone_detector
   import gtz_pkg::*;
#(
   parameter int DW      = 16,
   parameter int CW      = CFRAC + 2,
   parameter int SW      = 32,
   parameter int PW      = 32,
   parameter int BLK_LEN = 205,
   parameter int PSHIFT  = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic [CW-1:0] coeff,
   input  logic [DW-1:0] in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [PW-1:0] out_power,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          ovf
);

   localparam int CNTW = $clog2(BLK_LEN);
   localparam int AW   = 2 * SW + 2;
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BLK_LEN - 1);

   gtz_state_e state_q, state_d;
   logic [CNTW-1:0]      cnt_q, cnt_d;
   logic signed [SW-1:0] s1_q, s1_d, s2_q, s2_d, s0;
   logic [CW-1:0]        c_q, c_d;
   logic [PW-1:0]        out_power_q, out_power_d;
   logic                 out_valid_q, out_valid_d;
   logic                 ovf_q, ovf_d, s0_ovf;

   logic                 mac_en;
   mac_op_e              mac_op;
   logic signed [SW-1:0] mac_a, mac_b, c_ext, t_val;
   logic signed [SW+1:0] prod_sh, x_ext, s2_ext;
   logic signed [AW-1:0] acc_d, pwr_sh;
   logic [PW-1:0]        pwr_clamped;

   assign c_ext  = {{(SW-CW){c_q[CW-1]}}, c_q};
   assign x_ext  = {{(SW+2-DW){in_data[DW-1]}}, in_data};
   assign s2_ext = {{2{s2_q[SW-1]}}, s2_q};

`ifdef GTZ_SAT_EN
   logic signed [SW+1:0] s0_wide;
   longint               s0_sat;
   assign s0_wide = x_ext + prod_sh - s2_ext;
   assign s0_sat  = sat_signed(longint'(s0_wide), SW);
   assign s0      = SW'(s0_sat);
   assign s0_ovf  = (s0_sat != longint'(s0_wide));
`else
   assign s0     = SW'(x_ext + prod_sh - s2_ext);
   assign s0_ovf = 1'b0;
`endif

   gtz_mac #(
      .SW   (SW),
      .FRAC (CW - 2)
   ) u_mac (
      .clk       (clk),
      .rst       (rst),
      .en_i      (mac_en),
      .op_i      (mac_op),
      .a_i       (mac_a),
      .b_i       (mac_b),
      .prod_sh_o (prod_sh),
      .t_o       (t_val),
      .acc_d_o   (acc_d)
   );

   // Rounding in the c*s1*s2 term can push a near-zero power slightly negative.
   assign pwr_sh = acc_d >>> PSHIFT;
   always_comb begin
      if (pwr_sh[AW-1]) begin
         pwr_clamped = '0;
      end else if (|pwr_sh[AW-2:PW]) begin
         pwr_clamped = '1;
      end else begin
         pwr_clamped = pwr_sh[PW-1:0];
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      s1_d        = s1_q;
      s2_d        = s2_q;
      c_d         = c_q;
      out_power_d = out_power_q;
      out_valid_d = out_valid_q;
      ovf_d       = ovf_q;
      mac_en      = 1'b0;
      mac_op      = MAC_LOAD;
      mac_a       = c_ext;
      mac_b       = s1_q;
      in_ready    = (state_q == ST_ACCUM);

      case (state_q)
         ST_ACCUM: begin
            if (in_valid) begin
               s2_d  = s1_q;
               s1_d  = s0;
               cnt_d = cnt_q + CNTW'(1);
               ovf_d = ovf_q | s0_ovf;
               if (cnt_q == '0) begin
                  c_d = coeff;
               end
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_MUL1;
               end
            end
         end
         ST_MUL1: begin
            mac_en  = 1'b1;
            mac_op  = MAC_LOAD;
            mac_a   = s1_q;
            mac_b   = s1_q;
            state_d = ST_MUL2;
         end
         ST_MUL2: begin
            mac_en  = 1'b1;
            mac_op  = MAC_ADD;
            mac_a   = s2_q;
            mac_b   = s2_q;
            state_d = ST_MUL3;
         end
         ST_MUL3: begin
            mac_en  = 1'b1;
            mac_op  = MAC_PASS_SHIFT;
            mac_a   = c_ext;
            mac_b   = s1_q;
            state_d = ST_MUL4;
         end
         ST_MUL4: begin
            mac_en      = 1'b1;
            mac_op      = MAC_SUB;
            mac_a       = t_val;
            mac_b       = s2_q;
            out_power_d = pwr_clamped;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               s1_d        = '0;
               s2_d        = '0;
               cnt_d       = '0;
               ovf_d       = 1'b0;
               state_d     = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase

      if (clr) begin
         state_d     = ST_ACCUM;
         cnt_d       = '0;
         s1_d        = '0;
         s2_d        = '0;
         out_valid_d = 1'b0;
         ovf_d       = 1'b0;
         mac_en      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ACCUM;
         cnt_q       <= '0;
         s1_q        <= '0;
         s2_q        <= '0;
         c_q         <= '0;
         out_power_q <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         c_q         <= c_d;
         out_power_q <= out_power_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_power = out_power_q;
   assign out_valid = out_valid_q;
   assign ovf       = ovf_q;

endmodule
